skeeball_score_bcd: RTL and testbench
=====================================

Name: skeeball_score_bcd

Overview:
- Parametrised next-generation skeeball scorer: a BCD score accumulator for one game of NUM_BALLS balls.
- Score width is configurable (DIGITS BCD digits), with full multi-digit carry ripple and selectable saturate or wrap on overflow.
- Hole sensors are edge-detected, so each ball scores exactly once.
- Includes a game FSM with ball countdown and high-score retention. Sits between the debounced hole sensors and the score display driver.

Parameters:
- DIGITS, 3: number of BCD digits in score and high_score. Score unit is 10 points, so a 3-digit score covers 0–9990 points.
- NUM_BALLS, 9: balls per game, legal range 1–255.
- SATURATE, 1: overflow policy. 1 = clamp at all-9s; 0 = wrap modulo 10^DIGITS.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a new game
- hole  in  7  debounced, clk-synchronous sensor levels. Bits [6:0] = 100, 50, 40, 30, 20, 10, 0 (gutter).
- score  out  4*DIGITS  BCD score of the current game, or of the last game when idle
- balls_left  out  $clog2(NUM_BALLS+1)  balls remaining in the current game
- playing  out  1  high in PLAY
- game_over  out  1  high from game end until the next start
- overflow  out  1  sticky; set if the score exceeded 10^DIGITS-1 during this game
- high_score  out  4*DIGITS  best score since reset
- new_high  out  1  high with game_over if the last game strictly beat high_score

Behaviour:
- Reset (async, rst_n=0): state=IDLE. score, balls_left, high_score, the registered hole copy hole_q, and all flags are 0.
- Ball event: rise = hole & ~hole_q; event = |rise. hole_q <= hole every clk.
- Priority: if several bits rise in one cycle, the highest-value bit wins and exactly one ball is consumed.
- Increment in score units: 100→10, 50→5, 40→4, 30→3, 20→2, 10→1, 0→0.
- A level held high scores once only. A bit must fall and rise again to score again.
- Latency: the event is visible combinationally in cycle N. score, balls_left and overflow update on the rising edge ending cycle N.
- Arithmetic: the increment is added as BCD into digit 1 for 100 and into digit 0 otherwise. Carry ripples through all DIGITS in the same cycle; no multi-cycle add.
- Overflow, SATURATE=1: score becomes all 9s and overflow is set.
- Overflow, SATURATE=0: score wraps modulo 10^DIGITS and overflow is set.
- overflow stays set until the next start.
- Every digit of score is always in 0–9; an illegal digit code is never produced.
- FSM state IDLE: events are ignored. On start: score=0, balls_left=NUM_BALLS, overflow=0, game_over=0, new_high=0, then →PLAY.
- FSM state PLAY: each event adds its value and decrements balls_left. The event with balls_left==1 scores, sets balls_left=0, then →DONE. start is ignored.
- FSM state DONE (one cycle): compares score with high_score as unsigned (valid for BCD).
- If score > high_score: high_score<=score and new_high<=1.
- If score == high_score: high_score is unchanged and new_high stays 0.
- game_over<=1, then →IDLE.
- start and event in the same IDLE cycle: start wins and the event is discarded. hole_q still updates, so a held sensor does not score in PLAY.
- start in the DONE cycle: ignored.
- Reset mid-game: immediate return to IDLE with all values cleared, including high_score.

Decomposition:
- Package skeeball_pkg:
  - hole bit index constants HOLE_0 … HOLE_100
  - hole value table (score units)
  - state enum {IDLE, PLAY, DONE}
  - BCD digit typedef (4-bit)
- Sub-module bcd_digit_add: combinational, one digit.
  - Inputs: a[3:0], b[3:0], cin. Outputs: sum[3:0], cout.
  - Performs decimal correct on a result above 9.
  - Instantiated DIGITS times as a ripple chain.
- Top module: edge detect, priority encode, saturation/wrap, FSM, high-score register.

Test Plan:
- Reset, then start, then pulse hole[6] (100) for 3 cycles → score=010 BCD one cycle later (scored once), balls_left=8.
- DIGITS=3, score=095, hole 50 rises → score=100 (ripple across two digits), overflow=0.
- SATURATE=1, score=995, hole 100 rises → score=999, overflow=1. With SATURATE=0, same stimulus → score=005, overflow=1.
- hole 20 and hole 40 rise in the same cycle → +4 only, balls_left decrements by exactly 1.
- NUM_BALLS=2, start, hole 10 then hole 0 → after the DONE cycle: game_over=1, playing=0, score=001, high_score=001, new_high=1.
  - Replay the same game → new_high=0, high_score unchanged.
- Assert rst_n low mid-PLAY, asynchronously between clk edges → all outputs 0 immediately. Hole edges while IDLE → score unchanged.

Source files
------------

// File: rtl/skeeball_pkg.sv
// Shared types and constants for the BCD skeeball scorer: hole indices,
// hole values in score units, game state encoding and the BCD digit type.
package skeeball_pkg;

   localparam int unsigned HOLE_W   = 7;
   localparam int unsigned HOLE_0   = 0;
   localparam int unsigned HOLE_10  = 1;
   localparam int unsigned HOLE_20  = 2;
   localparam int unsigned HOLE_30  = 3;
   localparam int unsigned HOLE_40  = 4;
   localparam int unsigned HOLE_50  = 5;
   localparam int unsigned HOLE_100 = 6;

   // Value of each hole in score units (1 unit = 10 points), indexed by hole bit
   localparam int unsigned HOLE_VAL [HOLE_W] = '{0, 1, 2, 3, 4, 5, 10};

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit adder with carry; binary sums above 9 are decimal-corrected.
module bcd_digit_add
   import skeeball_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] w_bin;
   logic [4:0] w_adj;

   assign w_bin = 5'(a) + 5'(b) + 5'(cin);
   assign w_adj = w_bin + 5'd6;

   always_comb begin
      sum  = w_bin[3:0];
      cout = 1'b0;
      if (w_bin > 5'd9) begin
         sum  = w_adj[3:0];
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/skeeball_score_bcd.sv
// BCD skeeball score accumulator: edge-detected hole sensors, priority encode,
// ripple BCD add with saturate/wrap, game FSM and high-score retention.
module skeeball_score_bcd
   import skeeball_pkg::*;
#(
   parameter int unsigned DIGITS    = 3,
   parameter int unsigned NUM_BALLS = 9,
   parameter int unsigned SATURATE  = 1
)
(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [HOLE_W-1:0]                  hole,
   output logic [4*DIGITS-1:0]                score,
   output logic [$clog2(NUM_BALLS+1)-1:0]     balls_left,
   output logic                               playing,
   output logic                               game_over,
   output logic                               overflow,
   output logic [4*DIGITS-1:0]                high_score,
   output logic                               new_high
);

   localparam int unsigned SW = 4 * DIGITS;
   localparam int unsigned BW = $clog2(NUM_BALLS + 1);
   localparam logic [SW-1:0] ALL_NINES = {DIGITS{4'h9}};
   localparam bit ONE_DIGIT = (DIGITS == 1);

   state_t            r_state, w_state_nxt;
   logic [HOLE_W-1:0] r_hole_q;
   logic [SW-1:0]     r_score, w_score_nxt;
   logic [BW-1:0]     r_balls, w_balls_nxt;
   logic              r_playing;
   logic              r_game_over, w_game_over_nxt;
   logic              r_ovf, w_ovf_nxt;
   logic [SW-1:0]     r_high, w_high_nxt;
   logic              r_new_high, w_new_high_nxt;

   logic [HOLE_W-1:0] w_rise;
   logic              w_event;
   bcd_t              w_add_d0, w_add_d1;
   logic [SW-1:0]     w_sum;
   logic [DIGITS:0]   w_carry;
   logic              w_add_ovf;

   assign w_rise  = hole & ~r_hole_q;
   assign w_event = |w_rise;

   // Highest-value rising hole wins; 100 lands as a 1 in the tens digit
   always_comb begin
      w_add_d0 = '0;
      w_add_d1 = '0;
      for (int unsigned i = HOLE_0; i < HOLE_100; i++) begin
         if (w_rise[i]) w_add_d0 = 4'(HOLE_VAL[i]);
      end
      if (w_rise[HOLE_100]) begin
         w_add_d0 = '0;
         w_add_d1 = 4'd1;
      end
   end

   assign w_carry[0] = 1'b0;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_t w_b;
      if (g == 0) begin : g_d0
         assign w_b = w_add_d0;
      end else if (g == 1) begin : g_d1
         assign w_b = w_add_d1;
      end else begin : g_dn
         assign w_b = '0;
      end
      bcd_digit_add u_add (
         .a    (r_score[4*g +: 4]),
         .b    (w_b),
         .cin  (w_carry[g]),
         .sum  (w_sum[4*g +: 4]),
         .cout (w_carry[g+1])
      );
   end

   // A single-digit score has no tens digit, so a 100 always overflows
   assign w_add_ovf = w_carry[DIGITS] | (ONE_DIGIT & w_rise[HOLE_100]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_score_nxt     = r_score;
      w_balls_nxt     = r_balls;
      w_game_over_nxt = r_game_over;
      w_ovf_nxt       = r_ovf;
      w_high_nxt      = r_high;
      w_new_high_nxt  = r_new_high;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_score_nxt     = '0;
               w_balls_nxt     = BW'(NUM_BALLS);
               w_ovf_nxt       = 1'b0;
               w_game_over_nxt = 1'b0;
               w_new_high_nxt  = 1'b0;
               w_state_nxt     = PLAY;
            end
         end
         PLAY: begin
            if (w_event) begin
               w_score_nxt = w_sum;
               if (w_add_ovf) begin
                  w_ovf_nxt = 1'b1;
                  if (SATURATE != 0) w_score_nxt = ALL_NINES;
               end
               w_balls_nxt = r_balls - BW'(1);
               if (r_balls == BW'(1)) w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (r_score > r_high) begin
               w_high_nxt     = r_score;
               w_new_high_nxt = 1'b1;
            end
            w_game_over_nxt = 1'b1;
            w_state_nxt     = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hole_q    <= '0;
         r_score     <= '0;
         r_balls     <= '0;
         r_playing   <= 1'b0;
         r_game_over <= 1'b0;
         r_ovf       <= 1'b0;
         r_high      <= '0;
         r_new_high  <= 1'b0;
      end else begin
         r_hole_q    <= hole;
         r_score     <= w_score_nxt;
         r_balls     <= w_balls_nxt;
         r_playing   <= (w_state_nxt == PLAY);
         r_game_over <= w_game_over_nxt;
         r_ovf       <= w_ovf_nxt;
         r_high      <= w_high_nxt;
         r_new_high  <= w_new_high_nxt;
      end
   end

   assign score      = r_score;
   assign balls_left = r_balls;
   assign playing    = r_playing;
   assign game_over  = r_game_over;
   assign overflow   = r_ovf;
   assign high_score = r_high;
   assign new_high   = r_new_high;

endmodule

// File: tb/tb_skeeball_score_bcd.sv
// Directed bench for skeeball_score_bcd: a vector table for a full default game
// plus sequences for overflow, game end, replay and asynchronous reset.
module tb_skeeball_score_bcd;

   localparam logic [6:0] H100 = 7'h40;
   localparam logic [6:0] H50  = 7'h20;
   localparam logic [6:0] H40  = 7'h10;
   localparam logic [6:0] H30  = 7'h08;
   localparam logic [6:0] H20  = 7'h04;
   localparam logic [6:0] H10  = 7'h02;
   localparam logic [6:0] H0   = 7'h01;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [6:0] hole = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // a: default 9 balls saturating; s/w: 255 balls saturate/wrap; c: 2 balls
   logic [11:0] a_score, a_high, s_score, s_high, w_score, w_high, c_score, c_high;
   logic [3:0]  a_balls;
   logic [7:0]  s_balls, w_balls;
   logic [1:0]  c_balls;
   logic a_play, a_go, a_ovf, a_nh;
   logic s_play, s_go, s_ovf, s_nh;
   logic w_play, w_go, w_ovf, w_nh;
   logic c_play, c_go, c_ovf, c_nh;

   skeeball_score_bcd #(.DIGITS(3), .NUM_BALLS(9), .SATURATE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .hole(hole), .score(a_score),
      .balls_left(a_balls), .playing(a_play), .game_over(a_go), .overflow(a_ovf),
      .high_score(a_high), .new_high(a_nh));

   skeeball_score_bcd #(.DIGITS(3), .NUM_BALLS(255), .SATURATE(1)) u_s (
      .clk(clk), .rst_n(rst_n), .start(start), .hole(hole), .score(s_score),
      .balls_left(s_balls), .playing(s_play), .game_over(s_go), .overflow(s_ovf),
      .high_score(s_high), .new_high(s_nh));

   skeeball_score_bcd #(.DIGITS(3), .NUM_BALLS(255), .SATURATE(0)) u_w (
      .clk(clk), .rst_n(rst_n), .start(start), .hole(hole), .score(w_score),
      .balls_left(w_balls), .playing(w_play), .game_over(w_go), .overflow(w_ovf),
      .high_score(w_high), .new_high(w_nh));

   skeeball_score_bcd #(.DIGITS(3), .NUM_BALLS(2), .SATURATE(1)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start), .hole(hole), .score(c_score),
      .balls_left(c_balls), .playing(c_play), .game_over(c_go), .overflow(c_ovf),
      .high_score(c_high), .new_high(c_nh));

   typedef struct {
      logic        start;
      logic [6:0]  hole;
      logic [11:0] score;
      logic [3:0]  balls;
      logic        playing;
      logic        game_over;
      logic        new_high;
      logic [11:0] high;
   } vec_t;

   vec_t tbl [26];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic ball(input logic [6:0] h);
      @(negedge clk) hole = h;
      @(negedge clk) hole = '0;
   endtask

   task automatic start_pulse();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 7'h00, 12'h000, 4'd9, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[1]  = '{1'b0, H100,  12'h010, 4'd8, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[2]  = '{1'b0, H100,  12'h010, 4'd8, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[3]  = '{1'b0, H100,  12'h010, 4'd8, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[4]  = '{1'b0, 7'h00, 12'h010, 4'd8, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[5]  = '{1'b0, H50,   12'h015, 4'd7, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[6]  = '{1'b0, 7'h00, 12'h015, 4'd7, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[7]  = '{1'b0, H20 | H40, 12'h019, 4'd6, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[8]  = '{1'b0, 7'h00, 12'h019, 4'd6, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[9]  = '{1'b0, H40,   12'h023, 4'd5, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[10] = '{1'b0, 7'h00, 12'h023, 4'd5, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[11] = '{1'b0, H10,   12'h024, 4'd4, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[12] = '{1'b0, 7'h00, 12'h024, 4'd4, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[13] = '{1'b0, H0,    12'h024, 4'd3, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[14] = '{1'b0, 7'h00, 12'h024, 4'd3, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[15] = '{1'b0, H30,   12'h027, 4'd2, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[16] = '{1'b1, 7'h00, 12'h027, 4'd2, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[17] = '{1'b0, H100,  12'h037, 4'd1, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[18] = '{1'b0, 7'h00, 12'h037, 4'd1, 1'b1, 1'b0, 1'b0, 12'h000};
      tbl[19] = '{1'b0, H10,   12'h038, 4'd0, 1'b0, 1'b0, 1'b0, 12'h000};
      tbl[20] = '{1'b0, 7'h00, 12'h038, 4'd0, 1'b0, 1'b1, 1'b1, 12'h038};
      tbl[21] = '{1'b0, H50,   12'h038, 4'd0, 1'b0, 1'b1, 1'b1, 12'h038};
      tbl[22] = '{1'b0, 7'h00, 12'h038, 4'd0, 1'b0, 1'b1, 1'b1, 12'h038};
      tbl[23] = '{1'b1, H100,  12'h000, 4'd9, 1'b1, 1'b0, 1'b0, 12'h038};
      tbl[24] = '{1'b0, H100,  12'h000, 4'd9, 1'b1, 1'b0, 1'b0, 12'h038};
      tbl[25] = '{1'b0, 7'h00, 12'h000, 4'd9, 1'b1, 1'b0, 1'b0, 12'h038};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst score",    32'(a_score), 32'h0);
      chk("rst balls",    32'(a_balls), 32'h0);
      chk("rst playing",  32'(a_play),  32'h0);
      chk("rst gameover", 32'(a_go),    32'h0);
      chk("rst overflow", 32'(a_ovf),   32'h0);
      chk("rst high",     32'(a_high),  32'h0);
      chk("rst newhigh",  32'(a_nh),    32'h0);
      rst_n = 1'b1;

      // Full default game from the vector table
      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         start = tbl[i].start;
         hole  = tbl[i].hole;
         @(posedge clk);
         #1;
         chk($sformatf("row%0d score", i),    32'(a_score), 32'(tbl[i].score));
         chk($sformatf("row%0d balls", i),    32'(a_balls), 32'(tbl[i].balls));
         chk($sformatf("row%0d playing", i),  32'(a_play),  32'(tbl[i].playing));
         chk($sformatf("row%0d gameover", i), 32'(a_go),    32'(tbl[i].game_over));
         chk($sformatf("row%0d newhigh", i),  32'(a_nh),    32'(tbl[i].new_high));
         chk($sformatf("row%0d high", i),     32'(a_high),  32'(tbl[i].high));
         chk($sformatf("row%0d overflow", i), 32'(a_ovf),   32'h0);
      end
      @(negedge clk);
      start = 1'b0;
      hole  = '0;

      // Multi-digit ripple and overflow on the 255-ball instances
      do_reset();
      start_pulse();
      repeat (9) ball(H100);
      ball(H50);
      chk("s score 095", 32'(s_score), 32'h095);
      chk("w score 095", 32'(w_score), 32'h095);
      ball(H50);
      chk("s ripple 100", 32'(s_score), 32'h100);
      chk("s ripple ovf", 32'(s_ovf),   32'h0);
      repeat (89) ball(H100);
      chk("s score 990", 32'(s_score), 32'h990);
      ball(H50);
      chk("s score 995", 32'(s_score), 32'h995);
      chk("s ovf 995",   32'(s_ovf),   32'h0);
      chk("s balls 995", 32'(s_balls), 32'd154);
      ball(H100);
      chk("sat score", 32'(s_score), 32'h999);
      chk("sat ovf",   32'(s_ovf),   32'h1);
      chk("sat balls", 32'(s_balls), 32'd153);
      chk("wrap score", 32'(w_score), 32'h005);
      chk("wrap ovf",   32'(w_ovf),   32'h1);
      ball(H10);
      chk("sat hold score",  32'(s_score), 32'h999);
      chk("sat sticky ovf",  32'(s_ovf),   32'h1);
      chk("wrap post score", 32'(w_score), 32'h006);
      chk("wrap sticky ovf", 32'(w_ovf),   32'h1);

      // Two-ball game end and replay
      do_reset();
      start_pulse();
      ball(H10);
      ball(H0);
      @(negedge clk);
      chk("c1 gameover", 32'(c_go),    32'h1);
      chk("c1 playing",  32'(c_play),  32'h0);
      chk("c1 score",    32'(c_score), 32'h001);
      chk("c1 high",     32'(c_high),  32'h001);
      chk("c1 newhigh",  32'(c_nh),    32'h1);
      chk("c1 balls",    32'(c_balls), 32'h0);
      start_pulse();
      chk("c2 start newhigh",  32'(c_nh),   32'h0);
      chk("c2 start gameover", 32'(c_go),   32'h0);
      chk("c2 start playing",  32'(c_play), 32'h1);
      ball(H10);
      ball(H0);
      @(negedge clk);
      chk("c2 gameover", 32'(c_go),    32'h1);
      chk("c2 score",    32'(c_score), 32'h001);
      chk("c2 high",     32'(c_high),  32'h001);
      chk("c2 newhigh",  32'(c_nh),    32'h0);

      // Asynchronous reset in the middle of a game, then idle holes
      ball(H100);
      chk("a mid score",   32'(a_score), 32'h012);
      chk("a mid balls",   32'(a_balls), 32'd4);
      chk("a mid playing", 32'(a_play),  32'h1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async score",   32'(a_score), 32'h0);
      chk("async balls",   32'(a_balls), 32'h0);
      chk("async playing", 32'(a_play),  32'h0);
      chk("async gameover",32'(a_go),    32'h0);
      chk("async ovf",     32'(a_ovf),   32'h0);
      chk("async newhigh", 32'(a_nh),    32'h0);
      chk("async c high",  32'(c_high),  32'h0);
      @(negedge clk) rst_n = 1'b1;
      ball(H100);
      ball(H50);
      @(negedge clk);
      chk("idle score",   32'(a_score), 32'h0);
      chk("idle balls",   32'(a_balls), 32'h0);
      chk("idle playing", 32'(a_play),  32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
